comparador_rodada: RTL and testbench
====================================

# comparador_rodada

Round-level move comparator for the game datapath. It collects one move per player per round, each under its own strobe, with an optional inactivity timeout. It then compares the captured moves either against a target move or against each other. Per-player match flags, a match count and a round-done pulse go to the game control unit.

## Interface
Parameters:
- WIDTH, 4, bits per move
- N_JOGADORES, 2, number of players (≥2)
- TIMEOUT_CICLOS, 0, cycles allowed in collection; 0 disables the timeout

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- iniciar  in  1  start/restart a round
- habilita  in  1  when low, collection pauses: strobes are ignored and the timeout counter holds
- modo  in  1  0 = compare to alvo; 1 = compare players to player 0
- alvo  in  WIDTH  target move
- jogadas  in  N_JOGADORES*WIDTH  player i move in bits [i*WIDTH +: WIDTH]
- jogada_valida  in  N_JOGADORES  per-player move strobe
- ocupado  out  1  high in COLETA or COMPARA
- pronto  out  1  one-cycle pulse on entry to FIM
- acertos  out  N_JOGADORES  per-player match flags
- num_acertos  out  $clog2(N_JOGADORES+1)  popcount of acertos
- todos_iguais  out  1  all players captured with identical moves
- expirou  out  1  round closed by timeout

## Operation
- States:
  - OCIOSO: reset state.
  - COLETA: collecting moves.
  - COMPARA: one cycle; computes and registers results.
  - FIM: results are held here.
- OCIOSO/FIM + iniciar → COLETA. The same edge samples modo and alvo, clears the capture vector, move registers, timeout counter and all result outputs.
- iniciar in COLETA restarts the round with the same clearing. iniciar in COMPARA is ignored.
- Capture in COLETA, when habilita=1, jogada_valida[i]=1 and player i is not yet captured: register move i and set capturado[i].
  - Strobes after the first capture are ignored.
  - Strobes in the same cycle as iniciar are ignored.
- COLETA → COMPARA on the edge at which the next capture vector becomes all ones.
- Timeout (TIMEOUT_CICLOS>0): the counter increments on each COLETA cycle with habilita=1.
  - When it reaches TIMEOUT_CICLOS-1 with the vector incomplete, the state goes to COMPARA and expirou is set.
  - Uncaptured players count as non-matching.
- Final capture and timeout on the same cycle: the capture wins and expirou=0.
- Results, by mode:
  - modo=0: acertos[i] = capturado[i] & (move_i == alvo).
  - modo=1: acertos[i] = capturado[i] & capturado[0] & (move_i == move_0), so acertos[0] = capturado[0].
- todos_iguais = all captured and all moves equal to move 0, in either mode.
- COMPARA → FIM unconditionally. FIM holds all results until iniciar or reset.

## Timing
- Reset: state OCIOSO; ocupado, pronto, acertos, num_acertos, todos_iguais and expirou are all 0.
- Reset mid-round aborts the round; no pronto is issued.
- Final strobe sampled in cycle t: COMPARA in t+1; FIM with results valid and pronto=1 in t+2; pronto=0 from t+3.
- Timeout: with continuous habilita, pronto arrives TIMEOUT_CICLOS+1 cycles after the first COLETA cycle.
- ocupado falls in the same cycle pronto rises.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared defines file (jogo_defs.vh): default move width, modo encodings (MODO_ALVO=0, MODO_JOGADORES=1).
- State encoding stays as local parameters inside the module.
- One sub-module, contador_timeout: a parametrised counter with clear, enable and terminal-count output. It is instantiated only when TIMEOUT_CICLOS>0.
- Per-player capture and compare logic is written as a generate loop.

## Test plan
- N=2, modo=0, alvo=5; strobes move 5 (P0) at cycle 2 and move 3 (P1) at cycle 4 → pronto at cycle 6, acertos=01, num_acertos=1, todos_iguais=0, expirou=0.
- N=3, modo=1; moves 7,7,7 with P2 first and P0 last → acertos=111, num_acertos=3, todos_iguais=1.
- P0 strobes 2 then 9 → the first capture (2) is kept; a repeated strobe does not advance the state.
- TIMEOUT_CICLOS=8, only P0 strobes (matches alvo); habilita low for 3 cycles mid-round → pronto 12 cycles after COLETA entry, expirou=1, acertos=01.
- Final capture on the timeout cycle → expirou=0 and results as normal.
- Reset and restart:
  - reset in COLETA → all outputs 0 next cycle, and no pronto.
  - iniciar in COLETA → earlier captures are discarded.

Source files
------------

// File: rtl/comparador_rodada_pkg.sv
// rtl/comparador_rodada_pkg.sv - shared move width, mode encodings and per-player match rule
package comparador_rodada_pkg;

  localparam int WIDTH_PADRAO = 4;

  localparam logic MODO_ALVO      = 1'b0;
  localparam logic MODO_JOGADORES = 1'b1;

  // Match rule for one player: against the target, or against player 0
  function automatic logic acerto_jogador(
    input logic modo,
    input logic capt_i,
    input logic capt_0,
    input logic igual_p0,
    input logic igual_alvo
  );
    logic r;
    case (modo)
      MODO_ALVO:      r = capt_i & igual_alvo;
      MODO_JOGADORES: r = capt_i & capt_0 & igual_p0;
      default:        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/comparador_rodada_contador_timeout.sv
// rtl/comparador_rodada_contador_timeout.sv - collection inactivity counter with clear, enable and terminal count
module contador_timeout #(
  parameter int LIMITE = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic limpa,
  input  logic habilita,
  output logic terminal
);

  localparam int CW = (LIMITE > 1) ? $clog2(LIMITE) : 1;

  logic [CW-1:0] conta_q, conta_d;

  // Terminal count is reached on the last allowed cycle; the counter parks there
  assign terminal = (conta_q == CW'(LIMITE - 1));

  // Next count: clear wins, otherwise count enabled cycles up to the terminal value
  always_comb begin
    conta_d = conta_q;
    if (limpa) begin
      conta_d = '0;
    end else if (habilita && !terminal) begin
      conta_d = conta_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clock) begin
    if (reset) begin
      conta_q <= '0;
    end else begin
      conta_q <= conta_d;
    end
  end

endmodule

// File: rtl/comparador_rodada.sv
// rtl/comparador_rodada.sv - round-level move comparator: capture one move per player, then compare
module comparador_rodada
  import comparador_rodada_pkg::*;
#(
  parameter int WIDTH          = WIDTH_PADRAO,
  parameter int N_JOGADORES    = 2,
  parameter int TIMEOUT_CICLOS = 0
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              iniciar,
  input  logic                              habilita,
  input  logic                              modo,
  input  logic [WIDTH-1:0]                  alvo,
  input  logic [N_JOGADORES*WIDTH-1:0]      jogadas,
  input  logic [N_JOGADORES-1:0]            jogada_valida,
  output logic                              ocupado,
  output logic                              pronto,
  output logic [N_JOGADORES-1:0]            acertos,
  output logic [$clog2(N_JOGADORES+1)-1:0]  num_acertos,
  output logic                              todos_iguais,
  output logic                              expirou
);

  localparam int NW = $clog2(N_JOGADORES + 1);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    COLETA  = 2'd1,
    COMPARA = 2'd2,
    FIM     = 2'd3
  } estado_t;

  estado_t                      estado_q, estado_d;
  logic                         modo_q, modo_d;
  logic [WIDTH-1:0]             alvo_q, alvo_d;
  logic [N_JOGADORES-1:0]       capt_q, capt_d;
  logic [N_JOGADORES*WIDTH-1:0] moves_q, moves_d;
  logic [N_JOGADORES-1:0]       acertos_q, acertos_d;
  logic [NW-1:0]                num_q, num_d;
  logic                         iguais_q, iguais_d;
  logic                         expirou_q, expirou_d;
  logic                         pronto_q, pronto_d;
  logic                         ocupado_q, ocupado_d;

  logic [N_JOGADORES-1:0]       captura, capt_prox, igual_p0, acerto_calc;
  logic [N_JOGADORES*WIDTH-1:0] moves_cap;
  logic [NW-1:0]                num_calc;
  logic                         todos_calc;
  logic                         coleta_ativa, limpa, fim_tempo;

  // A strobe only counts while collecting, enabled, and not restarting in the same cycle
  assign coleta_ativa = (estado_q == COLETA) && habilita && !iniciar;
  assign capt_prox    = capt_q | captura;
  assign todos_calc   = (&capt_q) & (&igual_p0);

  for (genvar i = 0; i < N_JOGADORES; i++) begin : g_jogador
    assign captura[i] = coleta_ativa & jogada_valida[i] & ~capt_q[i];
    assign moves_cap[i*WIDTH +: WIDTH] = captura[i] ? jogadas[i*WIDTH +: WIDTH]
                                                    : moves_q[i*WIDTH +: WIDTH];
    assign igual_p0[i] = (moves_q[i*WIDTH +: WIDTH] == moves_q[WIDTH-1:0]);
    assign acerto_calc[i] = acerto_jogador(modo_q, capt_q[i], capt_q[0], igual_p0[i],
                                           moves_q[i*WIDTH +: WIDTH] == alvo_q);
  end

  if (TIMEOUT_CICLOS > 0) begin : g_timeout
    logic terminal;
    contador_timeout #(
      .LIMITE (TIMEOUT_CICLOS)
    ) u_contador (
      .clock    (clock),
      .reset    (reset),
      .limpa    (limpa),
      .habilita (coleta_ativa),
      .terminal (terminal)
    );
    assign fim_tempo = coleta_ativa & terminal;
  end else begin : g_sem_timeout
    assign fim_tempo = 1'b0;
  end

  // Popcount of the per-player match flags
  always_comb begin
    num_calc = '0;
    for (int i = 0; i < N_JOGADORES; i++) begin
      num_calc = num_calc + NW'(acerto_calc[i]);
    end
  end

  // Round sequencing, capture update and result registration
  always_comb begin
    estado_d  = estado_q;
    modo_d    = modo_q;
    alvo_d    = alvo_q;
    capt_d    = capt_q;
    moves_d   = moves_q;
    acertos_d = acertos_q;
    num_d     = num_q;
    iguais_d  = iguais_q;
    expirou_d = expirou_q;
    pronto_d  = 1'b0;
    limpa     = 1'b0;

    case (estado_q)
      OCIOSO, FIM: begin
        if (iniciar) begin
          estado_d = COLETA;
          limpa    = 1'b1;
        end
      end
      COLETA: begin
        if (iniciar) begin
          limpa = 1'b1;
        end else begin
          capt_d  = capt_prox;
          moves_d = moves_cap;
          if (&capt_prox) begin
            estado_d = COMPARA;
          end else if (fim_tempo) begin
            estado_d  = COMPARA;
            expirou_d = 1'b1;
          end
        end
      end
      COMPARA: begin
        estado_d  = FIM;
        acertos_d = acerto_calc;
        num_d     = num_calc;
        iguais_d  = todos_calc;
        pronto_d  = 1'b1;
      end
      default: estado_d = OCIOSO;
    endcase

    if (limpa) begin
      modo_d    = modo;
      alvo_d    = alvo;
      capt_d    = '0;
      moves_d   = '0;
      acertos_d = '0;
      num_d     = '0;
      iguais_d  = 1'b0;
      expirou_d = 1'b0;
    end

    ocupado_d = (estado_d == COLETA) || (estado_d == COMPARA);
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q  <= OCIOSO;
      modo_q    <= 1'b0;
      alvo_q    <= '0;
      capt_q    <= '0;
      moves_q   <= '0;
      acertos_q <= '0;
      num_q     <= '0;
      iguais_q  <= 1'b0;
      expirou_q <= 1'b0;
      pronto_q  <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      modo_q    <= modo_d;
      alvo_q    <= alvo_d;
      capt_q    <= capt_d;
      moves_q   <= moves_d;
      acertos_q <= acertos_d;
      num_q     <= num_d;
      iguais_q  <= iguais_d;
      expirou_q <= expirou_d;
      pronto_q  <= pronto_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign ocupado      = ocupado_q;
  assign pronto       = pronto_q;
  assign acertos      = acertos_q;
  assign num_acertos  = num_q;
  assign todos_iguais = iguais_q;
  assign expirou      = expirou_q;

endmodule

// File: tb/tb_comparador_rodada.sv
// tb/tb_comparador_rodada.sv - scoreboard bench for comparador_rodada with a round-level reference model
module tb_comparador_rodada;
  import comparador_rodada_pkg::*;

  localparam int W  = 4;
  localparam int N  = 3;
  localparam int T  = 8;
  localparam int JW = N * W;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          iniciar = 1'b0;
  logic          habilita = 1'b0;
  logic          modo = 1'b0;
  logic [W-1:0]  alvo = '0;
  logic [JW-1:0] jogadas = '0;
  logic [N-1:0]  jogada_valida = '0;
  logic          ocupado, pronto, todos_iguais, expirou;
  logic [N-1:0]  acertos;
  logic [1:0]    num_acertos;

  comparador_rodada #(
    .WIDTH          (W),
    .N_JOGADORES    (N),
    .TIMEOUT_CICLOS (T)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .iniciar       (iniciar),
    .habilita      (habilita),
    .modo          (modo),
    .alvo          (alvo),
    .jogadas       (jogadas),
    .jogada_valida (jogada_valida),
    .ocupado       (ocupado),
    .pronto        (pronto),
    .acertos       (acertos),
    .num_acertos   (num_acertos),
    .todos_iguais  (todos_iguais),
    .expirou       (expirou)
  );

  always #5 clock = ~clock;

  int ciclo = 0;
  always @(posedge clock) ciclo <= ciclo + 1;

  typedef struct {
    logic          hab;
    logic [N-1:0]  stb;
    logic [JW-1:0] mv;
  } passo_t;

  typedef struct {
    logic [N-1:0] ac;
    int           num;
    logic         ig;
    logic         ex;
    int           ciclo;
  } esperado_t;

  passo_t    roteiro[$];
  esperado_t fila[$];
  int        vetores = 0;
  int        erros = 0;

  task automatic checa(input string nome, input int valor, input int requerido);
    vetores++;
    if (valor !== requerido) begin
      erros++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nome, valor, requerido, ciclo);
    end
  endtask

  task automatic passo(input logic hab, input logic [N-1:0] stb,
                       input logic [W-1:0] m0, input logic [W-1:0] m1, input logic [W-1:0] m2);
    passo_t p;
    p.hab = hab;
    p.stb = stb;
    p.mv  = {m2, m1, m0};
    roteiro.push_back(p);
  endtask

  // Round-level model: walk the scripted cycles, keep first move per player,
  // close on a full set or when the T-th enabled cycle passes, then score.
  task automatic modelo(input logic modo_m, input logic [W-1:0] alvo_m,
                        output int fim, output esperado_t e);
    bit cap [N];
    int mv  [N];
    int k;
    bit todos, a;
    k     = 0;
    fim   = -1;
    e.ex  = 1'b0;
    for (int p = 0; p < N; p++) begin
      cap[p] = 1'b0;
      mv[p]  = 0;
    end
    for (int j = 0; j < roteiro.size() && fim < 0; j++) begin
      if (roteiro[j].hab) begin
        for (int p = 0; p < N; p++) begin
          if (roteiro[j].stb[p] && !cap[p]) begin
            cap[p] = 1'b1;
            mv[p]  = int'(roteiro[j].mv[p*W +: W]);
          end
        end
        todos = 1'b1;
        for (int p = 0; p < N; p++) todos &= cap[p];
        if (todos) begin
          fim = j;
        end else if (k == T - 1) begin
          fim  = j;
          e.ex = 1'b1;
        end
        k++;
      end
    end
    e.ac  = '0;
    e.num = 0;
    e.ig  = 1'b1;
    for (int p = 0; p < N; p++) begin
      if (modo_m == MODO_JOGADORES) a = cap[p] && cap[0] && (mv[p] == mv[0]);
      else                          a = cap[p] && (mv[p] == int'(alvo_m));
      e.ac[p] = a;
      e.num  += int'(a);
      e.ig   &= cap[p] && (mv[p] == mv[0]);
    end
  endtask

  // Issue one round; corte < 0 runs it to completion, otherwise stops after corte steps
  task automatic rodada(input logic modo_v, input logic [W-1:0] alvo_v,
                        input logic [N-1:0] ini_stb, input int corte);
    int fim, n, passos;
    esperado_t e;
    for (int i = 0; i < T; i++) passo(1'b1, '0, '0, '0, '0);
    modelo(modo_v, alvo_v, fim, e);
    if (fim < 0) begin
      $display("FAIL modelo: round never closes");
      $fatal(1);
    end
    @(posedge clock); #1;
    n             = ciclo;
    iniciar       = 1'b1;
    modo          = modo_v;
    alvo          = alvo_v;
    habilita      = 1'($urandom);
    jogada_valida = ini_stb;
    jogadas       = JW'($urandom);
    e.ciclo       = n + 3 + fim;
    if (corte < 0) fila.push_back(e);
    passos = (corte < 0) ? fim + 1 : corte;
    for (int j = 0; j < passos; j++) begin
      @(posedge clock); #1;
      iniciar       = 1'b0;
      habilita      = roteiro[j].hab;
      jogada_valida = roteiro[j].stb;
      jogadas       = roteiro[j].mv;
    end
    @(posedge clock); #1;
    iniciar       = 1'b0;
    habilita      = 1'b1;
    jogada_valida = '0;
    if (corte < 0) repeat (3) @(posedge clock);
    roteiro.delete();
  endtask

  // Monitor: every pronto pops one expected result; pronto must last one cycle
  initial begin
    bit prev;
    esperado_t e;
    prev = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev = 1'b0;
      end else begin
        if (prev) checa("pronto_pulse", int'(pronto), 0);
        if (pronto) begin
          if (fila.size() == 0) begin
            vetores++;
            erros++;
            $display("FAIL pronto_unexpected: got pronto=1, expected no round pending (cycle %0d)", ciclo);
          end else begin
            e = fila.pop_front();
            checa("acertos",      int'(acertos),      int'(e.ac));
            checa("num_acertos",  int'(num_acertos),  e.num);
            checa("todos_iguais", int'(todos_iguais), int'(e.ig));
            checa("expirou",      int'(expirou),      int'(e.ex));
            checa("pronto_cycle", ciclo,              e.ciclo);
            checa("ocupado_at_pronto", int'(ocupado), 0);
          end
        end
        prev = pronto;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic         m;
    logic [W-1:0] a, base;
    logic [N-1:0] s;
    logic [W-1:0] mv [N];
    int           len;

    repeat (3) @(posedge clock);
    #1;
    checa("reset_ocupado",      int'(ocupado),      0);
    checa("reset_pronto",       int'(pronto),       0);
    checa("reset_acertos",      int'(acertos),      0);
    checa("reset_num_acertos",  int'(num_acertos),  0);
    checa("reset_todos_iguais", int'(todos_iguais), 0);
    checa("reset_expirou",      int'(expirou),      0);
    reset = 1'b0;

    // target 5: P0 hits, P1 misses, P2 hits
    passo(1'b1, 3'b000, 4'd0, 4'd0, 4'd0);
    passo(1'b1, 3'b001, 4'd5, 4'd0, 4'd0);
    passo(1'b1, 3'b000, 4'd0, 4'd0, 4'd0);
    passo(1'b1, 3'b110, 4'd0, 4'd3, 4'd5);
    rodada(MODO_ALVO, 4'd5, 3'b000, -1);

    // player mode, all 7, P2 first and P0 last
    passo(1'b1, 3'b100, 4'd0, 4'd0, 4'd7);
    passo(1'b1, 3'b010, 4'd0, 4'd7, 4'd0);
    passo(1'b1, 3'b001, 4'd7, 4'd0, 4'd0);
    rodada(MODO_JOGADORES, 4'd3, 3'b000, -1);

    // repeated P0 strobes keep the first move and do not close the round
    passo(1'b1, 3'b001, 4'd2, 4'd0, 4'd0);
    passo(1'b1, 3'b001, 4'd9, 4'd0, 4'd0);
    passo(1'b1, 3'b010, 4'd9, 4'd2, 4'd0);
    passo(1'b1, 3'b001, 4'd9, 4'd0, 4'd0);
    passo(1'b1, 3'b100, 4'd0, 4'd0, 4'd2);
    rodada(MODO_ALVO, 4'd2, 3'b000, -1);

    // timeout with habilita low for three cycles; a strobe while paused is ignored
    passo(1'b1, 3'b001, 4'd6, 4'd0, 4'd0);
    passo(1'b1, 3'b000, 4'd0, 4'd0, 4'd0);
    passo(1'b0, 3'b000, 4'd0, 4'd0, 4'd0);
    passo(1'b0, 3'b010, 4'd0, 4'd6, 4'd0);
    passo(1'b0, 3'b000, 4'd0, 4'd0, 4'd0);
    rodada(MODO_ALVO, 4'd6, 3'b000, -1);

    // final capture lands on the timeout cycle
    passo(1'b1, 3'b011, 4'd9, 4'd9, 4'd0);
    for (int i = 0; i < 6; i++) passo(1'b1, 3'b000, 4'd0, 4'd0, 4'd0);
    passo(1'b1, 3'b100, 4'd0, 4'd0, 4'd9);
    rodada(MODO_ALVO, 4'd9, 3'b000, -1);

    // restart in COLETA discards P0/P1 captures; strobes with iniciar are ignored
    passo(1'b1, 3'b011, 4'd4, 4'd4, 4'd0);
    rodada(MODO_ALVO, 4'd4, 3'b000, 1);
    checa("ocupado_in_coleta", int'(ocupado), 1);
    passo(1'b1, 3'b100, 4'd0, 4'd0, 4'd4);
    passo(1'b1, 3'b011, 4'd1, 4'd2, 4'd0);
    rodada(MODO_ALVO, 4'd4, 3'b111, -1);

    // reset mid-round aborts without pronto
    passo(1'b1, 3'b001, 4'd1, 4'd0, 4'd0);
    rodada(MODO_ALVO, 4'd1, 3'b000, 1);
    checa("ocupado_before_reset", int'(ocupado), 1);
    reset = 1'b1;
    @(posedge clock); #1;
    checa("abort_ocupado",      int'(ocupado),      0);
    checa("abort_pronto",       int'(pronto),       0);
    checa("abort_acertos",      int'(acertos),      0);
    checa("abort_num_acertos",  int'(num_acertos),  0);
    checa("abort_todos_iguais", int'(todos_iguais), 0);
    checa("abort_expirou",      int'(expirou),      0);
    reset = 1'b0;
    repeat (4) @(posedge clock);

    // randomized rounds
    for (int r = 0; r < 40; r++) begin
      m    = 1'($urandom);
      a    = W'($urandom);
      base = m ? W'($urandom) : a;
      len  = $urandom_range(4, 14);
      for (int j = 0; j < len; j++) begin
        for (int p = 0; p < N; p++) begin
          s[p]  = ($urandom % 3) == 0;
          mv[p] = ($urandom % 2) ? base : W'($urandom);
        end
        passo(($urandom % 5) != 0, s, mv[0], mv[1], mv[2]);
      end
      rodada(m, a, N'($urandom), -1);
    end

    repeat (5) @(posedge clock);
    checa("pending_rounds", fila.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
    $finish;
  end

endmodule
